comparador_serial: RTL and testbench

Parametrised sequential magnitude comparator for WIDTH-bit operands, evaluated MSB-first in CHUNK-bit slices, one slice per clock. It produces registered lt/eq/gt flags and supports unsigned and two's-complement modes. It terminates early on the first differing slice. It is the shared comparison unit for datapaths that need wide operands without a single long combinational compare chain, using a start/busy/done handshake.

---
 rtl/comparador_serial_if.sv | 18 +
 rtl/comparador_serial.sv | 99 +++++++++
 tb/tb_comparador_serial.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/comparador_serial_if.sv
// Handshake/operand bundle for the serial magnitude comparator.
// The requester drives start/sgn/a/b; the comparator returns status and flags.
interface comparador_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (output start, sgn, a, b, input busy, done, lt, eq, gt);
  modport slave  (input start, sgn, a, b, output busy, done, lt, eq, gt);
endinterface

// File: rtl/comparador_serial.sv
// MSB-first sequential magnitude comparator: one CHUNK-bit slice per clock,
// early exit on the first differing slice, registered lt/eq/gt flags.
module comparador_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic clk,
  input  logic rst,
  comparador_serial_if.slave bus
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, done_q, done_d;

  // Ascending slice order so index 0 is the most significant slice.
  logic [0:NSLICE-1][CHUNK-1:0] ra_s, rb_s;
  logic [CHUNK-1:0]             sa, sb;

  assign ra_s = ra_q;
  assign rb_s = rb_q;
  assign sa   = ra_s[idx_q];
  assign sb   = rb_s[idx_q];

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          ra_d          = bus.a;
          rb_d          = bus.b;
          ra_d[WIDTH-1] = bus.a[WIDTH-1] ^ bus.sgn;
          rb_d[WIDTH-1] = bus.b[WIDTH-1] ^ bus.sgn;
          idx_d         = '0;
          state_d       = RUN;
        end
      end
      RUN: begin
        if (sa != sb) begin
          lt_d    = (sa < sb);
          gt_d    = (sa > sb);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == IDXW'(NSLICE - 1)) begin
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
endmodule

// File: tb/tb_comparador_serial.sv
// Directed and table-driven bench for comparador_serial (16/4 and 8/8 instances).
module tb_comparador_serial;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  comparador_serial_if #(.WIDTH(16)) bus16();
  comparador_serial_if #(.WIDTH(8))  bus8();

  comparador_serial #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  comparador_serial #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    int          lat;
    logic [2:0]  flg;  // {lt, eq, gt}
  } vec_t;

  int         n_pass = 0;
  int         n_tot  = 0;
  logic [2:0] prev16 = 3'b000;
  vec_t       tbl[11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden model: flags from native compares, latency from the MSB-first slice walk.
  task automatic model16(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                         output int lat, output logic [2:0] flg);
    logic [15:0] xa, xb;
    bit found;
    if (sgn) flg = {$signed(a) < $signed(b), a == b, $signed(a) > $signed(b)};
    else     flg = {a < b, a == b, a > b};
    xa = a ^ {sgn, 15'h0};
    xb = b ^ {sgn, 15'h0};
    lat = 4;
    found = 0;
    for (int i = 0; i < 4; i++) begin
      if (!found && (xa[15-4*i -: 4] != xb[15-4*i -: 4])) begin
        lat = i + 1;
        found = 1;
      end
    end
  endtask

  task automatic run16(input vec_t v, input string nm);
    int n;
    logic seen;
    bus16.a = v.a; bus16.b = v.b; bus16.sgn = v.sgn; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    bus16.a = ~v.a; bus16.b = 16'($urandom); bus16.sgn = ~v.sgn;
    chk({nm, " busy"}, 32'(bus16.busy), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 6) begin
      chk({nm, " hold"}, 32'({bus16.lt, bus16.eq, bus16.gt}), 32'(prev16));
      tick();
      n++;
      seen = bus16.done;
    end
    chk({nm, " latency"}, 32'(n), 32'(v.lat));
    chk({nm, " flags"}, 32'({bus16.lt, bus16.eq, bus16.gt}), 32'(v.flg));
    chk({nm, " idle"}, 32'(bus16.busy), 32'd0);
    prev16 = v.flg;
  endtask

  initial begin
    int lat;
    logic [2:0] flg;

    tbl[0]  = '{16'h1234, 16'h1235, 1'b0, 4, 3'b100};
    tbl[1]  = '{16'h8000, 16'h7FFF, 1'b0, 1, 3'b001};
    tbl[2]  = '{16'h8000, 16'h7FFF, 1'b1, 1, 3'b100};
    tbl[3]  = '{16'hABCD, 16'hABCD, 1'b0, 4, 3'b010};
    tbl[4]  = '{16'hABCD, 16'hABCD, 1'b1, 4, 3'b010};
    tbl[5]  = '{16'h1200, 16'h1300, 1'b0, 2, 3'b100};
    tbl[6]  = '{16'hFFFF, 16'h0001, 1'b1, 1, 3'b100};
    tbl[7]  = '{16'hFFFE, 16'hFFFF, 1'b1, 4, 3'b100};
    tbl[8]  = '{16'h0050, 16'h0040, 1'b0, 3, 3'b001};
    tbl[9]  = '{16'h0000, 16'h0000, 1'b1, 4, 3'b010};
    tbl[10] = '{16'h8000, 16'h8001, 1'b1, 4, 3'b100};

    rst = 1'b1;
    bus16.start = 1'b0; bus16.sgn = 1'b0; bus16.a = '0; bus16.b = '0;
    bus8.start  = 1'b0; bus8.sgn  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    tick();
    tick();
    chk("reset16", 32'({bus16.busy, bus16.done, bus16.lt, bus16.eq, bus16.gt}), 32'd0);
    chk("reset8",  32'({bus8.busy, bus8.done, bus8.lt, bus8.eq, bus8.gt}), 32'd0);
    rst = 1'b0;
    tick();

    // Directed table, issued back-to-back in each done cycle.
    for (int i = 0; i < 11; i++) run16(tbl[i], $sformatf("vec%0d", i));
    tick();

    // Reset in the second busy cycle aborts the compare with no done pulse.
    bus16.a = 16'h1234; bus16.b = 16'h1235; bus16.sgn = 1'b0; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("abort async", 32'({bus16.busy, bus16.done, bus16.lt, bus16.eq, bus16.gt}), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort no done", 32'({bus16.busy, bus16.done}), 32'd0);
    end
    prev16 = 3'b000;
    run16(tbl[0], "after abort");
    tick();

    // start held high with random operands; mid-run changes must be ignored.
    bus16.start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus16.a = 16'($urandom); bus16.sgn = 1'($urandom);
      bus16.b = ($urandom_range(0, 3) == 0) ? bus16.a ^ 16'(1 << $urandom_range(0, 15))
                                            : 16'($urandom);
      model16(bus16.a, bus16.b, bus16.sgn, lat, flg);
      tick();
      chk("rnd busy", 32'(bus16.busy), 32'd1);
      for (int j = 1; j <= lat; j++) begin
        bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.sgn = 1'($urandom);
        tick();
        if (j < lat) chk("rnd running", 32'({bus16.done, bus16.busy}), 32'b01);
        else chk($sformatf("rnd result %0d", i),
                 32'({bus16.done, bus16.busy, bus16.lt, bus16.eq, bus16.gt}),
                 32'({2'b10, flg}));
      end
    end
    bus16.start = 1'b0;
    tick();

    // Single-slice instance: registered compare with 1-cycle latency.
    bus8.a = 8'h05; bus8.b = 8'h0A; bus8.sgn = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    chk("w8 busy", 32'(bus8.busy), 32'd1);
    tick();
    chk("w8 05<0A", 32'({bus8.done, bus8.busy, bus8.lt, bus8.eq, bus8.gt}), 32'b10100);
    tick();

    // Every a against a stride of b values, back-to-back.
    bus8.start = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b += 5) begin
        bus8.a = 8'(a); bus8.b = 8'(b);
        tick();
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        tick();
        chk($sformatf("w8 %0h vs %0h", a, b),
            32'({bus8.done, bus8.busy, bus8.lt, bus8.eq, bus8.gt}),
            32'({2'b10, a < b, a == b, a > b}));
      end
    end
    bus8.start = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
